// File: rtl/tap_pkg.sv
// Shared state encoding and ASCII constants for the TAP stream checker.
package tap_pkg;
    localparam int TAP_CNT_WIDTH = 16;

    localparam logic [7:0] CH_LF   = 8'h0a;
    localparam logic [7:0] CH_CR   = 8'h0d;
    localparam logic [7:0] CH_SP   = 8'h20;
    localparam logic [7:0] CH_HASH = 8'h23;
    localparam logic [7:0] CH_DOT  = 8'h2e;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_1    = 8'h31;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_K    = 8'h6b;
    localparam logic [7:0] CH_N    = 8'h6e;
    localparam logic [7:0] CH_O    = 8'h6f;
    localparam logic [7:0] CH_T    = 8'h74;

    typedef enum logic [2:0] {
        LINE_START, MATCH_NOT, MATCH_OK, AFTER_OK, NUM, DESC, SKIP, RESULT
    } tap_state_e;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction
endpackage

// File: rtl/tap_dec_accum.sv
// Saturating decimal accumulator: value <= value*10 + digit, sticky overflow until cleared.
module tap_dec_accum #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         dig_vld_i,
    input  logic [3:0]   dig_i,
    output logic [W-1:0] val_o,
    output logic         has_dig_o,
    output logic         ovf_o
);
    logic [W-1:0] val_q;
    logic         has_q;
    logic         ovf_q;
    logic [W+3:0] next_w;

    // Four extra bits hold any value*10 + 9 without wrapping.
    assign next_w = ({4'b0, val_q} * (W+4)'(10)) + (W+4)'(dig_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            val_q <= '0;
            has_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (clr_i) begin
            val_q <= '0;
            has_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (dig_vld_i) begin
            has_q <= 1'b1;
            if (|next_w[W+3:W]) begin
                val_q <= '1;
                ovf_q <= 1'b1;
            end else begin
                val_q <= next_w[W-1:0];
            end
        end
    end

    assign val_o     = val_q;
    assign has_dig_o = has_q;
    assign ovf_o     = ovf_q;
endmodule

// File: rtl/tap_stream_checker.sv
// Byte-stream TAP parser: emits one ok/not-ok result per test line, tracks totals and numbering.
// Define TAP_STREAM_CHECKER_PLAN_EN to parse "1..N" plan lines into plan_o / done_o.
module tap_stream_checker
    import tap_pkg::*;
#(
    parameter int CNT_WIDTH  = TAP_CNT_WIDTH,
    parameter int PLAN_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [7:0]            data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  tc_valid_o,
    input  logic                  tc_ready_i,
    output logic                  tc_ok_o,
    output logic [CNT_WIDTH-1:0]  tc_num_o,
    output logic [CNT_WIDTH-1:0]  pass_cnt_o,
    output logic [CNT_WIDTH-1:0]  fail_cnt_o,
`ifdef TAP_STREAM_CHECKER_PLAN_EN
    output logic [PLAN_WIDTH-1:0] plan_o,
    output logic                  done_o,
`endif
    output logic                  seq_err_o,
    output logic                  fmt_err_o
);
`ifdef TAP_STREAM_CHECKER_PLAN_EN
    localparam bit PlanEn = 1'b1;
`else
    // Always false; PLAN_WIDTH only shapes logic when the plan feature is built.
    localparam bit PlanEn = (PLAN_WIDTH < 0);
`endif

    tap_state_e           state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic                 not_q, not_d;
    logic                 plan_mode_q, plan_mode_d;
    logic                 tc_ok_q, tc_ok_d;
    logic [CNT_WIDTH-1:0] tc_num_q, tc_num_d;
    logic [CNT_WIDTH-1:0] pass_q, pass_d, fail_q, fail_d, exp_q;
    logic                 seq_err_q, fmt_err_q, res_seen_q;
    logic                 dig_vld, xfer, acc_clr;
    logic [7:0]           pat;
    logic                 pat_last;
    logic [CNT_WIDTH-1:0] acc_val;
    logic                 acc_has, acc_ovf, plan_ovf;

    assign acc_clr = (state_q == LINE_START);

    tap_dec_accum #(.W(CNT_WIDTH)) u_num (
        .clk_i, .rst_i, .clr_i(acc_clr), .dig_vld_i(dig_vld & ~plan_mode_q),
        .dig_i(data_i[3:0]), .val_o(acc_val), .has_dig_o(acc_has), .ovf_o(acc_ovf)
    );

    // MATCH_OK expects "ok" after "not " (idx 0) but only "k" after a leading 'o' (idx 1).
    always_comb begin
        pat      = CH_SP;
        pat_last = 1'b0;
        if (state_q == MATCH_OK) begin
            pat = (idx_q == 2'd0) ? CH_O : CH_K;
        end else if (plan_mode_q) begin
            pat      = CH_DOT;
            pat_last = (idx_q == 2'd1);
        end else begin
            pat      = (idx_q == 2'd0) ? CH_O : (idx_q == 2'd1) ? CH_T : CH_SP;
            pat_last = (idx_q == 2'd2);
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        not_d       = not_q;
        plan_mode_d = plan_mode_q;
        tc_ok_d     = tc_ok_q;
        tc_num_d    = tc_num_q;
        dig_vld     = 1'b0;
        xfer        = 1'b0;
        if (state_q == RESULT) begin
            if (tc_ready_i) begin
                xfer    = 1'b1;
                state_d = LINE_START;
            end
        end else if (valid_i && data_i != CH_CR) begin
            unique case (state_q)
                LINE_START: begin
                    idx_d       = 2'd0;
                    not_d       = 1'b0;
                    plan_mode_d = 1'b0;
                    if (data_i == CH_N) begin
                        state_d = MATCH_NOT;
                    end else if (data_i == CH_O) begin
                        state_d = MATCH_OK;
                        idx_d   = 2'd1;
                    end else if (PlanEn && !res_seen_q && data_i == CH_1) begin
                        state_d     = MATCH_NOT;
                        plan_mode_d = 1'b1;
                    end else if (data_i != CH_LF) begin
                        state_d = SKIP;
                    end
                end
                MATCH_NOT: begin
                    if (data_i != pat) begin
                        state_d = (data_i == CH_LF) ? LINE_START : SKIP;
                    end else if (!pat_last) begin
                        idx_d = idx_q + 2'd1;
                    end else begin
                        idx_d = 2'd0;
                        if (plan_mode_q) begin
                            state_d = NUM;
                        end else begin
                            not_d   = 1'b1;
                            state_d = MATCH_OK;
                        end
                    end
                end
                MATCH_OK: begin
                    if (data_i != pat)
                        state_d = (data_i == CH_LF) ? LINE_START : SKIP;
                    else if (idx_q == 2'd1)
                        state_d = AFTER_OK;
                    else
                        idx_d = 2'd1;
                end
                AFTER_OK: begin
                    if (data_i == CH_SP) begin
                        state_d = NUM;
                    end else if (data_i == CH_LF) begin
                        tc_ok_d  = ~not_q;
                        tc_num_d = exp_q;
                        state_d  = RESULT;
                    end else begin
                        state_d = SKIP;
                    end
                end
                NUM: begin
                    if (is_digit(data_i)) begin
                        dig_vld = 1'b1;
                    end else if (data_i == CH_LF) begin
                        if (plan_mode_q) begin
                            state_d = LINE_START;
                        end else begin
                            tc_ok_d  = ~not_q;
                            tc_num_d = acc_has ? acc_val : exp_q;
                            state_d  = RESULT;
                        end
                    end else begin
                        state_d = plan_mode_q ? SKIP : DESC;
                    end
                end
                DESC: begin
                    if (data_i == CH_LF) begin
                        tc_ok_d  = ~not_q;
                        tc_num_d = acc_has ? acc_val : exp_q;
                        state_d  = RESULT;
                    end
                end
                SKIP: if (data_i == CH_LF) state_d = LINE_START;
                default: state_d = LINE_START;
            endcase
        end
    end

    always_comb begin
        pass_d = pass_q;
        fail_d = fail_q;
        if (xfer) begin
            if (tc_ok_q) begin
                if (pass_q != '1) pass_d = pass_q + CNT_WIDTH'(1);
            end else if (fail_q != '1) begin
                fail_d = fail_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= LINE_START;
            idx_q       <= 2'd0;
            not_q       <= 1'b0;
            plan_mode_q <= 1'b0;
            tc_ok_q     <= 1'b0;
            tc_num_q    <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
            exp_q       <= CNT_WIDTH'(1);
            seq_err_q   <= 1'b0;
            fmt_err_q   <= 1'b0;
            res_seen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            not_q       <= not_d;
            plan_mode_q <= plan_mode_d;
            tc_ok_q     <= tc_ok_d;
            tc_num_q    <= tc_num_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            if (xfer) begin
                // Resync to the received number so a single gap flags once.
                exp_q      <= tc_num_q + CNT_WIDTH'(1);
                res_seen_q <= 1'b1;
                if (tc_num_q != exp_q) seq_err_q <= 1'b1;
            end
            if (acc_ovf || plan_ovf) fmt_err_q <= 1'b1;
        end
    end

`ifdef TAP_STREAM_CHECKER_PLAN_EN
    logic [PLAN_WIDTH-1:0] plan_val, plan_q;
    logic                  plan_has, done_q;

    tap_dec_accum #(.W(PLAN_WIDTH)) u_plan (
        .clk_i, .rst_i, .clr_i(acc_clr), .dig_vld_i(dig_vld & plan_mode_q),
        .dig_i(data_i[3:0]), .val_o(plan_val), .has_dig_o(plan_has), .ovf_o(plan_ovf)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            plan_q <= '0;
            done_q <= 1'b0;
        end else begin
            if (state_q == NUM && plan_mode_q && valid_i && data_i == CH_LF && plan_has)
                plan_q <= plan_val;
            if (xfer && plan_q != '0 && (32'(pass_d) + 32'(fail_d) == 32'(plan_q)))
                done_q <= 1'b1;
        end
    end

    assign plan_o = plan_q;
    assign done_o = done_q;
`else
    assign plan_ovf = 1'b0;
`endif

    assign ready_o    = (state_q != RESULT);
    assign tc_valid_o = (state_q == RESULT);
    assign tc_ok_o    = tc_ok_q;
    assign tc_num_o   = tc_num_q;
    assign pass_cnt_o = pass_q;
    assign fail_cnt_o = fail_q;
    assign seq_err_o  = seq_err_q;
    assign fmt_err_o  = fmt_err_q;
endmodule

// File: tb/tb_tap_stream_checker.sv
// Scoreboard bench for tap_stream_checker: expected results queued at stimulus time, popped on transfer.
module tb_tap_stream_checker;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  data_i = 8'h00;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        tc_valid_o;
    logic        tc_ready_i = 1'b1;
    logic        tc_ok_o;
    logic [15:0] tc_num_o, pass_cnt_o, fail_cnt_o;
    logic        seq_err_o, fmt_err_o;
`ifdef TAP_STREAM_CHECKER_PLAN_EN
    logic [15:0] plan_o;
    logic        done_o;
`endif

    tap_stream_checker dut (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .tc_valid_o(tc_valid_o), .tc_ready_i(tc_ready_i), .tc_ok_o(tc_ok_o), .tc_num_o(tc_num_o),
        .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o),
`ifdef TAP_STREAM_CHECKER_PLAN_EN
        .plan_o(plan_o), .done_o(done_o),
`endif
        .seq_err_o(seq_err_o), .fmt_err_o(fmt_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        ok;
        logic [15:0] num;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_res(input logic ok, input logic [15:0] num);
        sb.push_back('{ok: ok, num: num});
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && tc_valid_o && tc_ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected result", 32'(tc_num_o), 32'hffff_ffff);
            end else begin
                mon_e = sb.pop_front();
                chk("tc_ok", 32'(tc_ok_o), 32'(mon_e.ok));
                chk("tc_num", 32'(tc_num_o), 32'(mon_e.num));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        #2 rst_i = 1'b0;
        #1;
    endtask

    task automatic send_byte(input byte b);
        int n = 0;
        @(negedge clk_i);
        data_i  = b;
        valid_i = 1'b1;
        while (!ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (!ready_o) chk("ready timeout", 32'(ready_o), 32'd1);
        @(posedge clk_i);
        #1 valid_i = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || tc_valid_o) && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (sb.size() != 0 || tc_valid_o) chk("drain timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst ready", 32'(ready_o), 32'd1);
        chk("rst tc_valid", 32'(tc_valid_o), 32'd0);
        chk("rst tc_ok", 32'(tc_ok_o), 32'd0);
        chk("rst tc_num", 32'(tc_num_o), 32'd0);
        chk("rst pass", 32'(pass_cnt_o), 32'd0);
        chk("rst fail", 32'(fail_cnt_o), 32'd0);
        chk("rst seq_err", 32'(seq_err_o), 32'd0);
        chk("rst fmt_err", 32'(fmt_err_o), 32'd0);
`ifdef TAP_STREAM_CHECKER_PLAN_EN
        chk("rst plan", 32'(plan_o), 32'd0);
        chk("rst done", 32'(done_o), 32'd0);
`endif

        // ok / not ok with descriptions
        expect_res(1'b1, 16'd1);
        expect_res(1'b0, 16'd2);
        send_str("ok 1 a\nnot ok 2 b\n");
        wait_drain();
        chk("basic pass", 32'(pass_cnt_o), 32'd1);
        chk("basic fail", 32'(fail_cnt_o), 32'd1);
        chk("basic seq_err", 32'(seq_err_o), 32'd0);

        // numbering gap flags on the jump only
        do_reset();
        expect_res(1'b1, 16'd1);
        send_str("ok 1\n");
        wait_drain();
        chk("gap seq before", 32'(seq_err_o), 32'd0);
        expect_res(1'b1, 16'd3);
        send_str("ok 3\n");
        wait_drain();
        chk("gap seq after 3", 32'(seq_err_o), 32'd1);
        expect_res(1'b1, 16'd4);
        send_str("ok 4\n");
        wait_drain();
        chk("gap pass", 32'(pass_cnt_o), 32'd3);

        // comments, plan-like lines, "okay" produce nothing; bare "ok" numbers itself
        do_reset();
        expect_res(1'b1, 16'd1);
        expect_res(1'b1, 16'd2);
        send_str("1..3\n# c\nokay\nok\nok\n");
        wait_drain();
        chk("skip pass", 32'(pass_cnt_o), 32'd2);
        chk("skip seq_err", 32'(seq_err_o), 32'd0);

        // consumer back-pressure
        do_reset();
        tc_ready_i = 1'b0;
        expect_res(1'b1, 16'd1);
        send_str("ok 1\n");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("stall tc_valid", 32'(tc_valid_o), 32'd1);
            chk("stall ready", 32'(ready_o), 32'd0);
            chk("stall tc_num", 32'(tc_num_o), 32'd1);
            chk("stall tc_ok", 32'(tc_ok_o), 32'd1);
        end
        @(posedge clk_i);
        #1 tc_ready_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("post xfer ready", 32'(ready_o), 32'd1);
        chk("post xfer tc_valid", 32'(tc_valid_o), 32'd0);
        chk("post xfer pass", 32'(pass_cnt_o), 32'd1);
        expect_res(1'b1, 16'd2);
        send_str("ok 2\n");
        wait_drain();

        // reset mid-line discards the partial line
        do_reset();
        send_str("not ok 1");
        do_reset();
        chk("midrst tc_valid", 32'(tc_valid_o), 32'd0);
        chk("midrst fail", 32'(fail_cnt_o), 32'd0);
        expect_res(1'b1, 16'd1);
        send_str("ok 1\n");
        wait_drain();
        chk("midrst pass", 32'(pass_cnt_o), 32'd1);
        chk("midrst fail after", 32'(fail_cnt_o), 32'd0);
        chk("midrst seq_err", 32'(seq_err_o), 32'd0);

        // CR ignored; "not ok" without number
        do_reset();
        expect_res(1'b1, 16'd1);
        expect_res(1'b0, 16'd2);
        send_str("ok 1\r\nnot ok\n");
        wait_drain();
        chk("cr pass", 32'(pass_cnt_o), 32'd1);
        chk("cr fail", 32'(fail_cnt_o), 32'd1);
        chk("cr fmt_err", 32'(fmt_err_o), 32'd0);

        // test number overflow saturates
        do_reset();
        expect_res(1'b1, 16'hffff);
        send_str("ok 99999 big\n");
        wait_drain();
        chk("ovf fmt_err", 32'(fmt_err_o), 32'd1);
        chk("ovf pass", 32'(pass_cnt_o), 32'd1);

`ifdef TAP_STREAM_CHECKER_PLAN_EN
        do_reset();
        send_str("1..2\n");
        chk("plan value", 32'(plan_o), 32'd2);
        expect_res(1'b1, 16'd1);
        send_str("ok 1\n");
        wait_drain();
        chk("plan done early", 32'(done_o), 32'd0);
        expect_res(1'b1, 16'd2);
        send_str("ok 2\n");
        wait_drain();
        chk("plan done", 32'(done_o), 32'd1);
        send_str("1..5\n");
        chk("late plan ignored", 32'(plan_o), 32'd2);
`endif

        repeat (3) @(negedge clk_i);
        chk("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
